// File: rtl/lfsr_encrypt_engine.sv
// Message encrypter: pads a plaintext to 64 bytes, XORs each byte with a 7-bit LFSR stream, and writes the ciphertext with even parity in bit 7.
// Latency: 131 cycles from an accepted start to the last write; done follows on the next cycle.
// No backpressure: the memory port is combinational, and a start seen while busy is ignored.
module lfsr_encrypt_engine #(
   parameter int          MSG_BASE = 0,
   parameter int          MSG_MAX  = 61,
   parameter int          CFG_BASE = 61,
   parameter int          OUT_BASE = 64,
   parameter int          NBYTES   = 64,
   parameter logic [7:0]  PAD_CHAR = 8'h20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic       done,
   output logic       busy,
   output logic [7:0] mem_addr,
   input  logic [7:0] mem_rdata,
   output logic       mem_wen,
   output logic [7:0] mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE, S_CFG0, S_CFG1, S_CFG2, S_RD, S_WR, S_DONE
   } state_t;

   state_t     state_q, state_d;
   logic [6:0] cnt_q,   cnt_d;
   logic [3:0] pre_q,   pre_d;
   logic [6:0] ptrn_q,  ptrn_d;
   logic [6:0] lfsr_q,  lfsr_d;
   logic [7:0] p_q,     p_d;

   logic [7:0] j;
   logic       in_msg;
   logic [6:0] c;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pre_d     = pre_q;
      ptrn_d    = ptrn_q;
      lfsr_d    = lfsr_q;
      p_d       = p_q;
      mem_addr  = '0;
      mem_wen   = 1'b0;
      mem_wdata = '0;
      done      = (state_q == S_DONE);
      busy      = (state_q != S_IDLE) && (state_q != S_DONE);

      // j is one bit wider than the counter; the explicit i >= pre test keeps leading-pad bytes from wrapping into the message.
      j      = {1'b0, cnt_q} - {4'b0000, pre_q};
      in_msg = (cnt_q >= {3'b000, pre_q}) && (j < 8'(MSG_MAX));
      c      = p_q[6:0] ^ lfsr_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_CFG0;
               cnt_d   = '0;
            end
         end
         S_CFG0: begin
            mem_addr = 8'(CFG_BASE);
            pre_d    = mem_rdata[3:0];
            state_d  = S_CFG1;
         end
         S_CFG1: begin
            mem_addr = 8'(CFG_BASE + 1);
            ptrn_d   = mem_rdata[6:0];
            state_d  = S_CFG2;
         end
         S_CFG2: begin
            mem_addr = 8'(CFG_BASE + 2);
            // An all-zero seed would lock the LFSR, so it is replaced by 1.
            lfsr_d   = (mem_rdata[6:0] == 7'h00) ? 7'h01 : mem_rdata[6:0];
            state_d  = S_RD;
         end
         S_RD: begin
            if (in_msg) begin
               mem_addr = 8'(MSG_BASE) + j;
               p_d      = mem_rdata;
            end else begin
               p_d      = PAD_CHAR;
            end
            state_d = S_WR;
         end
         S_WR: begin
            mem_addr  = 8'(OUT_BASE) + {1'b0, cnt_q};
            mem_wen   = 1'b1;
            mem_wdata = {^c, c};
            lfsr_d    = {lfsr_q[5:0], ^(lfsr_q & ptrn_q)};
            if (cnt_q == 7'(NBYTES - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d   = cnt_q + 7'd1;
               state_d = S_RD;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         pre_q   <= '0;
         ptrn_q  <= '0;
         lfsr_q  <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pre_q   <= pre_d;
         ptrn_q  <= ptrn_d;
         lfsr_q  <= lfsr_d;
         p_q     <= p_d;
      end
   end

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Bench for lfsr_encrypt_engine: a behavioural memory, a reference encrypter and a write scoreboard.
module tb_lfsr_encrypt_engine;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       done;
   logic       busy;
   logic [7:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       mem_wen;
   logic [7:0] mem_wdata;

   logic [7:0]  dm [0:255];
   logic [15:0] exp_q [$];
   logic [7:0]  exp_img [0:63];
   logic [6:0]  lfsr_seq [0:63];
   logic [7:0]  padded [0:63];
   logic [7:0]  saved_img [0:63];
   logic [15:0] mon_e;
   int          total = 0;
   int          bad = 0;

   lfsr_encrypt_engine dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .done      (done),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .mem_wen   (mem_wen),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   assign mem_rdata = dm[mem_addr];

   always @(posedge clk) begin
      if (mem_wen === 1'b1) dm[mem_addr] <= mem_wdata;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Every write the DUT makes must match the head of the expected-write queue.
   always @(negedge clk) begin
      if (mem_wen === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            check("wr_addr", 32'(mem_addr), 32'(mon_e[15:8]));
            check("wr_data", 32'(mem_wdata), 32'(mon_e[7:0]));
         end
      end
   end

   // The reference reads the plaintext and config from the current memory image.
   task automatic build_model(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] init_b);
      int pre, ptrn, s, jj, cv;
      pre  = int'(pre_b) % 16;
      ptrn = int'(ptrn_b) % 128;
      s    = int'(init_b) % 128;
      if (s == 0) s = 1;
      for (int i = 0; i < 64; i++) begin
         lfsr_seq[i] = 7'(s);
         jj = i - pre;
         if (jj >= 0 && jj < 61) padded[i] = dm[jj];
         else                    padded[i] = 8'h20;
         cv = (int'(padded[i]) % 128) ^ s;
         exp_img[i] = 8'(cv + 128 * ($countones(cv) % 2));
         s = ((s * 2) % 128) + ($countones(s & ptrn) % 2);
      end
   endtask

   task automatic push_expected();
      for (int i = 0; i < 64; i++) exp_q.push_back({8'(64 + i), exp_img[i]});
   endtask

   task automatic start_and_check();
      int n, ok;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
      check("done_after_start", 32'(done), 32'd0);
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("done_latency", 32'(n), 32'd131);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      ok = 0;
      for (int i = 0; i < 64; i++) begin
         if (dm[64 + i] === exp_img[i]) ok++;
         if (((dm[64 + i][6:0] ^ lfsr_seq[i]) === padded[i][6:0]) && (^dm[64 + i] === 1'b0)) ok++;
      end
      check("image_and_roundtrip", 32'(ok), 32'd128);
      repeat (3) @(posedge clk);
      #1;
      check("done_held", 32'(done), 32'd1);
      check("busy_clear", 32'(busy), 32'd0);
   endtask

   task automatic run(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] init_b);
      dm[61] = pre_b;
      dm[62] = ptrn_b;
      dm[63] = init_b;
      build_model(pre_b, ptrn_b, init_b);
      push_expected();
      start_and_check();
   endtask

   task automatic fill_msg_spaces();
      for (int i = 0; i < 61; i++) dm[i] = 8'h20;
   endtask

   initial begin
      logic [7:0] taps [0:8];
      logic [7:0] r;
      taps = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
      for (int i = 0; i < 256; i++) dm[i] = 8'h00;

      rst   = 1'b1;
      start = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
         check("rst_done", 32'(done), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_wen", 32'(mem_wen), 32'd0);
      end
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_done", 32'(done), 32'd0);

      // Pad-only stream
      fill_msg_spaces();
      run(8'h0A, 8'h60, 8'h01);
      check("pad_dm64", 32'(dm[64]), 32'h21);
      check("pad_dm65", 32'(dm[65]), 32'h22);
      check("pad_dm70", 32'(dm[70]), 32'hE1);

      // First message byte lands after ten leading pads
      dm[0] = 8'h41;
      run(8'h0A, 8'h60, 8'h01);
      check("msg_dm74", 32'(dm[74]), 32'h59);

      // Round trip over every legal tap set
      for (int t = 0; t < 9; t++) begin
         fill_msg_spaces();
         for (int i = 0; i < 49; i++) dm[i] = 8'($urandom_range(32, 126));
         r = 8'($urandom_range(0, 15));
         run({r[3:0], 4'($urandom_range(10, 15))}, {1'b0, taps[t][6:0]} | {r[0], 7'h00},
             {1'($urandom_range(0, 1)), 7'($urandom_range(1, 127))});
      end

      // Zero seed behaves like seed 1
      run(8'h0C, 8'h48, 8'h01);
      for (int i = 0; i < 64; i++) saved_img[i] = dm[64 + i];
      run(8'h0C, 8'h48, 8'h00);
      begin
         int same;
         same = 0;
         for (int i = 0; i < 64; i++) if (dm[64 + i] === saved_img[i]) same++;
         check("zero_init_same", 32'(same), 32'd64);
      end

      // Raw bytes with bit 7 set, and pre_length at both extremes
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 61; i++) dm[i] = 8'($urandom_range(0, 255));
         r = (k == 0) ? 8'hF0 : (k == 1) ? 8'h0F : 8'($urandom_range(0, 255));
         run(r, taps[$urandom_range(0, 8)], 8'($urandom_range(0, 255)));
      end

      // Reset in the middle of a run, then a clean relaunch
      fill_msg_spaces();
      for (int i = 0; i < 30; i++) dm[i] = 8'($urandom_range(32, 126));
      dm[61] = 8'h0B;
      dm[62] = 8'h78;
      dm[63] = 8'h35;
      build_model(8'h0B, 8'h78, 8'h35);
      push_expected();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (59) @(posedge clk);
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      check("midrst_wen", 32'(mem_wen), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("post_rst_idle", 32'(busy), 32'd0);
      run(8'h0B, 8'h78, 8'h35);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      bad++;
      $display("FAIL watchdog: simulation still running at time limit");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lfsr_encrypt_engine.md
# lfsr_encrypt_engine

Hardware message encrypter: the transmit-side counterpart of the program-2 decryption flow. On `start` it reads a plaintext message and its configuration from data memory. It pads the message with leading and trailing ASCII spaces to 64 bytes and XORs each byte with a 7-bit maximal-length LFSR stream. It writes each ciphertext byte, with even parity in bit 7, to data memory 64..127, which is the exact image the decrypt program consumes. It sits beside `top_level` as a bus master on the data memory port.

## Interface
Parameters:
- `MSG_BASE`, 0: first plaintext byte address.
- `MSG_MAX`, 61: plaintext region length (bytes `MSG_BASE`..`MSG_BASE+60`).
- `CFG_BASE`, 61: config addresses. `CFG_BASE` holds pre_length, `+1` holds tap pattern, `+2` holds LFSR init.
- `OUT_BASE`, 64: first ciphertext address.
- `NBYTES`, 64: ciphertext length.
- `PAD_CHAR`, 8'h20: padding character.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request, sampled on rising edge.
- `done` out 1: run complete, level.
- `busy` out 1: high from the cycle after `start` is accepted until `done` rises.
- `mem_addr` out 8: data memory address.
- `mem_rdata` in 8: data memory read data, combinational from `mem_addr`.
- `mem_wen` out 1: write enable.
- `mem_wdata` out 8: write data.

## Operation
- States: IDLE, CFG0, CFG1, CFG2, RD, WR, DONE.
- IDLE/DONE with `start`=1 → CFG0. The byte counter i is cleared and `done` falls.
- CFG0: `mem_addr`=`CFG_BASE`. Latch pre_length = `mem_rdata[3:0]`, used unclamped (0..15).
- CFG1: `mem_addr`=`CFG_BASE+1`. Latch ptrn = `mem_rdata[6:0]`.
- CFG2: `mem_addr`=`CFG_BASE+2`. Latch state = `mem_rdata[6:0]`; if that value is 0, substitute 7'h01.
- RD, byte i:
  - Compute j = i − pre_length.
  - If i ≥ pre_length and j < `MSG_MAX`, drive `mem_addr`=`MSG_BASE`+j and latch `mem_rdata` as p.
  - Otherwise p = `PAD_CHAR`; `mem_addr` is don't-care and no read side effects occur.
- WR, byte i:
  - Drive `mem_addr`=`OUT_BASE`+i and `mem_wen`=1.
  - c[6:0] = p[6:0] ^ state; `mem_wdata` = {^c[6:0], c[6:0]}. Bit 7 of p is discarded.
  - Advance state ← {state[5:0], ^(state & ptrn)}.
  - If i = `NBYTES`−1 → DONE; else i←i+1 and → RD.
- The LFSR state used for byte i is lfsr[i]: lfsr[0] = init, then one shift per byte. All 7-bit arithmetic is unsigned with no carries.
- j is computed in ≥7 bits so that negative values (i < pre_length) are detected, not wrapped.
- `start` while busy is ignored. `start` in DONE relaunches and re-reads the config.
- Memory writes occur only in WR. Addresses below `OUT_BASE` are never written.

## Timing
- Reset values: state IDLE; `done`=0, `busy`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0; internal registers 0.
- `start` high at edge k: CFG0 during cycle k+1, CFG1 at k+2, CFG2 at k+3.
- Byte i: RD at cycle k+4+2i, WR at k+5+2i. The last write is at k+131.
- `done`=1 from cycle k+132 and held until the next accepted `start` or `rst`.
- Fixed latency: 131 cycles from `start` to the last write, independent of data.
- `rst` mid-run: from the first edge with `rst`=1 the block is in IDLE with `mem_wen`=0. Bytes already written remain; no partial byte is written.
- `rst` and `start` both high on the same edge: `rst` wins, block in IDLE.

## Test plan
- Reset: hold `rst` for 2 cycles with `start`=1 → `done`=0, `busy`=0, `mem_wen`=0; no writes occur.
- Pad-only stream: DM[0..60]=0x20, pre_length=10, ptrn=0x60, init=0x01 → DM[64]=0x21, DM[65]=0x22, DM[70]=0xE1. `done` rises exactly 132 cycles after `start`.
- Message byte: same config with DM[0]=0x41 ('A') → DM[74]=0x59, since lfsr[10]=0x18 and the result has even parity, so bit 7 is 0.
- Round trip: random config (pre_length 10..15, each of the 9 legal taps, random nonzero init, 49-char string), then run program 2 → 64/64 bytes match the padded plaintext. Bench model: `msg_crypto[i] = padded[i]^lfsr[i]`, with bit 7 = parity.
- Zero init: DM[63]=0x00 → output identical to the init=0x01 run.
- Reset at cycle k+60 followed by a new `start` → the second run completes normally. No writes occur between the reset and the new CFG0, and the final DM[64..127] equals the golden result.
